// File: rtl/keypad_encoder_pkg.sv
// Shared constants and FSM state type for the keypad time-entry front end.
// The countdown timer imports BCD_W from here so both sides agree on digit width.
package keypad_encoder_pkg;

    localparam int BCD_W     = 4;
    localparam int KEY_COUNT = 10;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        LOAD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

endpackage

// File: rtl/keypad_encoder_stable_counter.sv
// Saturating stability counter used for both the press and release debounce phases.
// The synchronous clear wins over the increment.
module stable_counter #(
    parameter int CNT_W           = 5,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic clear,
    input  logic inc,
    output logic done
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DEBOUNCE_CYCLES);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != LIMIT)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign done = (count == LIMIT);

endmodule

// File: rtl/keypad_encoder.sv
// Keypad front end: synchronises the raw key lines, debounces a single pressed key,
// emits one active-low load strobe with its BCD digit, then waits for a clean release.
module keypad_encoder
    import keypad_encoder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic                 clock,
    input  logic                 clearn,
    input  logic [KEY_COUNT-1:0] keypad,
    input  logic                 enable,
    output logic [BCD_W-1:0]     data_out,
    output logic                 loadn,
    output logic                 busy
);

    state_t               state;
    state_t               next_state;
    logic [KEY_COUNT-1:0] sync_q;
    logic [KEY_COUNT-1:0] ks;
    logic [KEY_COUNT-1:0] cand;
    logic [BCD_W-1:0]     cand_bcd;
    logic                 ks_valid;
    logic                 cand_load;
    logic                 cnt_clear;
    logic                 cnt_inc;
    logic                 cnt_done;

    always_ff @(posedge clock) begin
        if (!clearn) begin
            sync_q <= '0;
            ks     <= '0;
        end else begin
            sync_q <= keypad;
            ks     <= sync_q;
        end
    end

    // A key counts only when exactly one line is set; chords and silence look the same.
    always_comb begin
        ks_valid = (ks != '0) && ((ks & (ks - KEY_COUNT'(1))) == '0);
    end

    always_comb begin
        cand_bcd = '0;
        for (int k = 0; k < KEY_COUNT; k++) begin
            if (cand[k]) begin
                cand_bcd = BCD_W'(k);
            end
        end
    end

    stable_counter #(
        .CNT_W           (CNT_W),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_stable_counter (
        .clock (clock),
        .clear (cnt_clear || !clearn),
        .inc   (cnt_inc),
        .done  (cnt_done)
    );

    always_ff @(posedge clock) begin
        if (!clearn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The counter value at DEBOUNCE entry already includes the sample that IDLE accepted.
    always_comb begin
        next_state = state;
        cnt_clear  = 1'b0;
        cnt_inc    = 1'b0;
        cand_load  = 1'b0;
        case (state)
            IDLE: begin
                if (enable && ks_valid) begin
                    next_state = DEBOUNCE;
                    cnt_inc    = 1'b1;
                    cand_load  = 1'b1;
                end else begin
                    cnt_clear = 1'b1;
                end
            end
            DEBOUNCE: begin
                if (ks != cand) begin
                    next_state = IDLE;
                    cnt_clear  = 1'b1;
                end else if (!enable) begin
                    next_state = RELEASE;
                    cnt_clear  = 1'b1;
                end else if (cnt_done) begin
                    next_state = LOAD;
                    cnt_clear  = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            LOAD: begin
                next_state = RELEASE;
                cnt_clear  = 1'b1;
            end
            RELEASE: begin
                if (ks != '0) begin
                    cnt_clear = 1'b1;
                end else if (cnt_done) begin
                    next_state = IDLE;
                    cnt_clear  = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
                cnt_clear  = 1'b1;
            end
        endcase
    end

    // data_out changes only on entry to LOAD so the timer sees a stable digit.
    always_ff @(posedge clock) begin
        if (!clearn) begin
            cand     <= '0;
            data_out <= '0;
        end else begin
            if (cand_load) begin
                cand <= ks;
            end
            if (next_state == LOAD) begin
                data_out <= cand_bcd;
            end
        end
    end

    always_comb begin
        loadn = (state != LOAD);
        busy  = (state != IDLE);
    end

endmodule

// File: tb/tb_keypad_encoder.sv
// Scoreboard bench for keypad_encoder with a short debounce: stimulus queues expected
// strobes (digit plus arrival window), a negedge monitor checks every strobe it sees.
module tb_keypad_encoder;
    import keypad_encoder_pkg::*;

    localparam int DEB = 4;

    typedef struct {
        logic [3:0] digit;
        int         lo;
        int         hi;
    } exp_t;

    logic       clock = 1'b0;
    logic       clearn;
    logic [9:0] keypad;
    logic       enable;
    logic [3:0] data_out;
    logic       loadn;
    logic       busy;

    int   cycle       = 0;
    int   vectors     = 0;
    int   miscompares = 0;
    exp_t sb_q[$];

    keypad_encoder #(
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (5)
    ) dut (
        .clock    (clock),
        .clearn   (clearn),
        .keypad   (keypad),
        .enable   (enable),
        .data_out (data_out),
        .loadn    (loadn),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycle <= cycle + 1;

    // Every observed strobe must match the oldest outstanding expectation.
    always @(negedge clock) begin
        exp_t e;
        if (loadn === 1'b0) begin
            if (sb_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_strobe: data_out=%0d at cycle %0d, required no strobe",
                         data_out, cycle);
            end else begin
                e = sb_q.pop_front();
                vectors++;
                if (data_out !== e.digit) begin
                    miscompares++;
                    $display("[TB] FAIL strobe_digit: data_out=%0d, required %0d", data_out, e.digit);
                end
                vectors++;
                if (cycle < e.lo || cycle > e.hi) begin
                    miscompares++;
                    $display("[TB] FAIL strobe_time: cycle %0d, required %0d..%0d", cycle, e.lo, e.hi);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic apply_stimulus(input logic [9:0] keys, input logic en, input int n);
        keypad = keys;
        enable = en;
        tick(n);
    endtask

    task automatic expect_strobe(input logic [3:0] digit, input int lo, input int hi);
        exp_t e;
        e.digit = digit;
        e.lo    = lo;
        e.hi    = hi;
        sb_q.push_back(e);
    endtask

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
        end
    endtask

    task automatic check_idle_outputs(input string tag, input logic [3:0] digit);
        @(negedge clock);
        check_output({tag, "_data_out"}, 32'(data_out), 32'(digit));
        check_output({tag, "_loadn"},    32'(loadn),    32'd1);
        check_output({tag, "_busy"},     32'(busy),     32'd0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        int c;
        int r0;
        logic [9:0] seq_keys;
        logic [3:0] seq_digits [3];
        seq_digits[0] = 4'd1;
        seq_digits[1] = 4'd2;
        seq_digits[2] = 4'd0;

        clearn = 1'b0;
        keypad = '0;
        enable = 1'b1;
        tick(2);
        check_idle_outputs("reset", 4'd0);
        clearn = 1'b1;
        tick(5);
        check_idle_outputs("post_reset", 4'd0);

        // Clean press of 5, then release and watch busy around the release window.
        c = cycle;
        expect_strobe(4'd5, c + 7, c + 7);
        apply_stimulus(10'b00_0010_0000, 1'b1, 20);
        r0 = cycle;
        apply_stimulus(10'b0, 1'b1, 4);
        @(negedge clock);
        check_output("release_busy_hold", 32'(busy), 32'd1);
        check_output("held_digit", 32'(data_out), 32'd5);
        tick(4);
        tick(r0 + 8 - cycle);
        @(negedge clock);
        check_output("release_busy_drop", 32'(busy), 32'd0);
        tick(4);

        // Bounce on key 3: five 2-cycle phases ending pressed, then held.
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                c = cycle;
                expect_strobe(4'd3, c + 7, c + 7);
            end
            apply_stimulus((i % 2 == 0) ? 10'b00_0000_1000 : 10'b0, 1'b1, 2);
        end
        tick(14);
        apply_stimulus(10'b0, 1'b1, 12);
        check_idle_outputs("bounce_done", 4'd3);

        // Chord of 1 and 7 is ignored until 7 lifts.
        apply_stimulus(10'b00_1000_0010, 1'b1, 20);
        @(negedge clock);
        check_output("chord_busy", 32'(busy), 32'd0);
        tick(1);
        c = cycle;
        expect_strobe(4'd1, c + 7, c + 7);
        apply_stimulus(10'b00_0000_0010, 1'b1, 12);
        apply_stimulus(10'b0, 1'b1, 12);
        check_idle_outputs("chord_done", 4'd1);

        // Key 9 held while disabled, accepted once enable rises.
        apply_stimulus(10'b10_0000_0000, 1'b0, 12);
        @(negedge clock);
        check_output("disabled_busy", 32'(busy), 32'd0);
        tick(1);
        c = cycle;
        expect_strobe(4'd9, c + 1, c + 12);
        apply_stimulus(10'b10_0000_0000, 1'b1, 14);
        apply_stimulus(10'b0, 1'b1, 12);
        check_idle_outputs("enable_done", 4'd9);

        for (int i = 0; i < 3; i++) begin
            seq_keys = 10'b1 << seq_digits[i];
            c = cycle;
            expect_strobe(seq_digits[i], c + 7, c + 7);
            apply_stimulus(seq_keys, 1'b1, 12);
            apply_stimulus(10'b0, 1'b1, 12);
            @(negedge clock);
            check_output("seq_digit", 32'(data_out), 32'(seq_digits[i]));
            tick(1);
        end

        // Key 8 interrupted by clearn while debouncing.
        apply_stimulus(10'b01_0000_0000, 1'b1, 4);
        @(negedge clock);
        check_output("debounce_busy", 32'(busy), 32'd1);
        tick(1);
        clearn = 1'b0;
        keypad = '0;
        tick(1);
        check_idle_outputs("mid_clear", 4'd0);
        clearn = 1'b1;
        tick(12);
        check_idle_outputs("after_clear", 4'd0);

        check_output("pending_strobes", 32'(sb_q.size()), 32'd0);
        while (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            $display("[TB] FAIL missing_strobe: digit %0d never seen, required by cycle %0d",
                     e.digit, e.hi);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
